// File: rtl/vit_pkg.sv
// vit_pkg: types and geometry shared by the ViT patchifier and embedding front end.
package vit_pkg;
    localparam int VIT_PIXEL_WIDTH       = 24;
    localparam int VIT_TOTAL_NUM_PATCHES = 16;
    localparam int VIT_PATCH_VECTOR_SIZE = 256;
    localparam int VIT_BEAT_PIXELS       = 4;
    localparam int VIT_TIMEOUT_CYCLES    = 8192;
    typedef enum logic [1:0] {
        PF_IDLE       = 2'd0,
        PF_PROCESSING = 2'd1,
        PF_DONE       = 2'd2
    } pf_state_t;
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_PF, S_STREAM, S_DRAIN, S_RELEASE
    } sched_state_t;
endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: single-entry valid/ready output register; can_load_o says a load will not overwrite a pending beat.
module stream_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         ready_i,
    input  logic [W-1:0] data_i,
    output logic         can_load_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end
    assign can_load_o = !valid_q || ready_i;
    assign valid_o    = valid_q;
    assign data_o     = data_q;
endmodule

// File: rtl/patch_stream_sched.sv
// patch_stream_sched: launches one patchification per start, then streams all_patches
// as BEAT_PIXELS-wide valid/ready beats and releases the patchifier.
module patch_stream_sched
    import vit_pkg::*;
#(
    parameter int PIXEL_WIDTH       = VIT_PIXEL_WIDTH,
    parameter int TOTAL_NUM_PATCHES = VIT_TOTAL_NUM_PATCHES,
    parameter int PATCH_VECTOR_SIZE = VIT_PATCH_VECTOR_SIZE,
    parameter int BEAT_PIXELS       = VIT_BEAT_PIXELS,
    parameter int TIMEOUT_CYCLES    = VIT_TIMEOUT_CYCLES
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic                                 pf_en,
    output logic                                 pf_output_taken,
    input  logic [1:0]                           pf_state,
    output logic [$clog2(TOTAL_NUM_PATCHES)-1:0] rd_patch,
    output logic [$clog2(PATCH_VECTOR_SIZE)-1:0] rd_pos,
    input  logic [BEAT_PIXELS*PIXEL_WIDTH-1:0]   rd_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [BEAT_PIXELS*PIXEL_WIDTH-1:0]   out_data,
    output logic [$clog2(TOTAL_NUM_PATCHES)-1:0] out_patch,
    output logic                                 out_sop,
    output logic                                 out_eop,
    output logic                                 out_eof
);
    localparam int BEATS = PATCH_VECTOR_SIZE / BEAT_PIXELS;
    localparam int PW    = $clog2(TOTAL_NUM_PATCHES);
    localparam int VW    = $clog2(PATCH_VECTOR_SIZE);
    localparam int BW    = $clog2(BEATS);
    localparam int TW    = $clog2(TIMEOUT_CYCLES);
    localparam int DW    = BEAT_PIXELS * PIXEL_WIDTH;

    sched_state_t  state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [PW-1:0] patch_q, patch_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d, stale_q, stale_d, done_q;
    logic          last_beat, last_patch, can_load, load;

    assign last_beat  = beat_q == BW'(BEATS - 1);
    assign last_patch = patch_q == PW'(TOTAL_NUM_PATCHES - 1);
    assign load       = (state_q == S_STREAM) && can_load;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        patch_d = patch_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        stale_d = stale_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LAUNCH;
                err_d   = 1'b0;
            end
            // A DONE seen before we launched is left over from an earlier job: release it and relaunch.
            S_LAUNCH: if (pf_state == PF_PROCESSING) begin
                state_d = S_WAIT_PF;
                tmo_d   = '0;
            end else if (pf_state == PF_DONE) begin
                state_d = S_RELEASE;
                stale_d = 1'b1;
            end
            S_WAIT_PF: if (pf_state == PF_DONE) begin
                state_d = S_STREAM;
                beat_d  = '0;
                patch_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            S_STREAM: if (load) begin
                beat_d  = last_beat ? '0 : beat_q + 1'b1;
                patch_d = last_beat ? (last_patch ? '0 : patch_q + 1'b1) : patch_q;
                state_d = (last_beat && last_patch) ? S_DRAIN : S_STREAM;
            end
            S_DRAIN: if (out_valid && out_ready) state_d = S_RELEASE;
            S_RELEASE: begin
                state_d = stale_q ? S_LAUNCH : S_IDLE;
                stale_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            patch_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            stale_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            patch_q <= patch_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            stale_q <= stale_d;
            done_q  <= (state_q == S_RELEASE) && !stale_q;
        end
    end

    stream_out_reg #(.W(PW + 3 + DW)) u_out (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .ready_i    (out_ready),
        .data_i     ({patch_q, beat_q == '0, last_beat, last_beat && last_patch, rd_data}),
        .can_load_o (can_load),
        .valid_o    (out_valid),
        .data_o     ({out_patch, out_sop, out_eop, out_eof, out_data})
    );

    assign busy            = state_q != S_IDLE;
    assign done            = done_q;
    assign err             = err_q;
    assign pf_en           = (state_q == S_LAUNCH) && (pf_state == PF_IDLE);
    assign pf_output_taken = state_q == S_RELEASE;
    assign rd_patch        = patch_q;
    assign rd_pos          = VW'(beat_q) * VW'(BEAT_PIXELS);
endmodule

// File: tb/tb_patch_stream_sched.sv
// tb_patch_stream_sched: job table plus reset sequences, beats scored against pixel(patch,pos) arithmetic.
module tb_patch_stream_sched;
    localparam int TOT_P = 16;
    localparam int PVS   = 256;
    localparam int BP    = 4;
    localparam int BPP   = PVS / BP;
    localparam int TOT   = TOT_P * BPP;

    typedef struct {
        int lat, hang, stale, rmode, storm;
        int beats, dn, tk, er, en, bz;
    } job_t;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic        busy, done, err, pf_en, pf_output_taken, out_valid, out_sop, out_eop, out_eof;
    logic [1:0]  pf_state;
    logic [3:0]  rd_patch, out_patch;
    logic [7:0]  rd_pos;
    logic [95:0] rd_data, out_data;

    int errors = 0, checks = 0;
    int n = 0, done_cnt = 0, taken_cnt = 0, en_cnt = 0, busy_cnt = 0;
    int pf_lat = 10, hang = 0, rmode = 0, storm = 0, pf_cnt = 0;
    logic stale_arm = 1'b0, prev_vs = 1'b0, prev_taken = 1'b0;
    logic [127:0] prev_word = '0;
    job_t jobs[6];

    always #5 clk = ~clk;

    patch_stream_sched dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .pf_en(pf_en), .pf_output_taken(pf_output_taken), .pf_state(pf_state),
        .rd_patch(rd_patch), .rd_pos(rd_pos), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_patch(out_patch), .out_sop(out_sop), .out_eop(out_eop), .out_eof(out_eof)
    );

    function automatic logic [23:0] pix(int p, int q);
        return 24'(p * PVS + q);
    endfunction

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < BP; i++) rd_data[i*24 +: 24] = pix(int'(rd_patch), int'(rd_pos) + i);
    end

    // Patchifier model: PROCESSING one cycle after en, DONE after pf_lat cycles, IDLE on release.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_state <= 2'd0;
            pf_cnt   <= 0;
        end else begin
            case (pf_state)
                2'd0: if (pf_en) begin
                    pf_state <= 2'd1;
                    pf_cnt   <= 0;
                end else if (stale_arm) pf_state <= 2'd2;
                2'd1: if (hang == 0) begin
                    pf_cnt <= pf_cnt + 1;
                    if (pf_cnt + 1 >= pf_lat) pf_state <= 2'd2;
                end
                2'd2: if (pf_output_taken) pf_state <= 2'd0;
                default: pf_state <= 2'd0;
            endcase
        end
    end

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] exp_beat(int k);
        int p = k / BPP;
        int b = k % BPP;
        logic [95:0] d;
        for (int i = 0; i < BP; i++) d[i*24 +: 24] = pix(p, b * BP + i);
        return 128'({1'b1, 4'(p), b == 0, b == BPP - 1, k == TOT - 1, d});
    endfunction

    function automatic logic [127:0] ow();
        return 128'({out_valid, out_patch, out_sop, out_eop, out_eof, out_data});
    endfunction

    function automatic logic [127:0] allout();
        return 128'({busy, done, err, pf_en, pf_output_taken, rd_patch, rd_pos,
                     out_valid, out_data, out_patch, out_sop, out_eop, out_eof});
    endfunction

    task automatic tick();
        @(negedge clk);
        if (prev_vs) check("stall_hold", ow(), prev_word);
        if (done) begin
            check("done_after_taken", 128'(prev_taken), 128'(1));
            done_cnt++;
        end
        if (pf_output_taken) taken_cnt++;
        if (pf_en) en_cnt++;
        if (busy) busy_cnt++;
        out_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        start     = (storm != 0 && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (out_valid && out_ready) begin
            check("beat", ow(), exp_beat(n));
            n++;
        end
        prev_vs    = out_valid && !out_ready && !reset;
        prev_word  = ow();
        prev_taken = pf_output_taken;
    endtask

    task automatic run_job(job_t j);
        pf_lat = j.lat; hang = j.hang; rmode = j.rmode; storm = j.storm;
        if (j.stale != 0) begin
            stale_arm = 1'b1;
            tick();
            stale_arm = 1'b0;
        end
        tick();
        n = 0; done_cnt = 0; taken_cnt = 0; en_cnt = 0; busy_cnt = 0;
        start = 1'b1;
        tick();
        check("err_clear", 128'(err), 128'(0));
        for (int k = 0; k < 20000 && done_cnt == 0 && err == 1'b0; k++) tick();
        repeat (20) tick();
        check("beats", 128'(n), 128'(j.beats));
        check("done_count", 128'(done_cnt), 128'(j.dn));
        check("taken_count", 128'(taken_cnt), 128'(j.tk));
        check("err_final", 128'(err), 128'(j.er));
        check("idle_after", 128'(busy), 128'(0));
        if (j.en >= 0) check("en_count", 128'(en_cnt), 128'(j.en));
        if (j.bz >= 0) check("busy_cycles", 128'(busy_cnt), 128'(j.bz));
    endtask

    initial begin
        jobs[0] = '{4096, 0, 0, 0, 0, TOT, 1, 1, 0, 1, -1};
        jobs[1] = '{int'($urandom_range(10, 40)), 0, 0, 1, 0, TOT, 1, 1, 0, 1, -1};
        jobs[2] = '{100, 1, 0, 0, 0, 0, 0, 0, 1, 1, 8194};
        jobs[3] = '{5, 0, 0, 1, 0, TOT, 1, 1, 0, -1, -1};
        jobs[4] = '{20, 0, 1, 1, 0, TOT, 1, 2, 0, 1, -1};
        jobs[5] = '{15, 0, 0, 0, 1, TOT, 1, 1, 0, 1, -1};
        repeat (3) tick();
        check("reset_state", allout(), '0);
        reset = 1'b0;
        repeat (2) tick();
        check("idle_state", allout(), '0);
        for (int i = 0; i < 6; i++) run_job(jobs[i]);
        pf_lat = 10; hang = 0; rmode = 0; storm = 0;
        n = 0;
        start = 1'b1;
        tick();
        for (int k = 0; k < 5000 && n < 300; k++) tick();
        check("reach_beat_300", 128'(n), 128'(300));
        #2 reset = 1'b1;
        #1 check("async_reset", allout(), '0);
        tick();
        reset = 1'b0;
        run_job('{30, 0, 0, 0, 0, TOT, 1, 1, 0, 1, -1});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
